// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB SRAM responder with wait states and ERROR response; AHB_SRAM_ALIGN_CHECK_EN enables misalignment errors
module ahb_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state, state_nxt;
    logic [3:0]      wait_cnt, wait_cnt_nxt;
    logic [AW-1:0]   idx_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            write_q;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            legal;
    logic            size_bad;
    logic            addr_bad;
    logic            align_bad;
    logic [31:0]     word_addr;
    logic [3:0]      be;
    logic            commit;
    logic [AW-1:0]   rd_idx;
    logic [31:0]     rd_word;
    logic [31:0]     rd_merged;
    logic            rd_fire;

    logic            unused_ok;
    assign unused_ok = ^{HTRANS[0], HBURST, HPROT};

    // Only the cycles that drive HREADYOUT high may take a new address phase.
    assign accept = HSEL && HREADY && HTRANS[1] &&
                    (state == S_IDLE || state == S_DATA || state == S_ERR2);

    assign word_addr = {2'b00, HADDR[31:2]};
    assign size_bad  = (HSIZE > 3'd2);
    assign addr_bad  = (word_addr >= 32'(DEPTH));
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    assign align_bad = ((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
    assign align_bad = 1'b0;
`endif
    assign legal = !(size_bad || addr_bad || align_bad);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_DATA;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (!accept) begin
                    state_nxt = S_IDLE;
                end else if (!legal) begin
                    state_nxt = S_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = WS_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            idx_q   <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= HADDR[AW+1:2];
            off_q   <= HADDR[1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE && legal;
        end
    end

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be = 4'b0001 << off_q;
            2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign commit = (state == S_DATA) && write_q && !HRESET;

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // A read landing on the word being written this cycle sees the merged result.
    assign rd_idx  = (state == S_WAIT) ? idx_q : HADDR[AW+1:2];
    assign rd_word = mem[rd_idx];

    always_comb begin
        rd_merged = rd_word;
        if (commit && (rd_idx == idx_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    assign rd_fire = (accept && legal && !HWRITE && (WAIT_STATES == 0)) ||
                     ((state == S_WAIT) && (wait_cnt == 4'd0) && !write_q);

    always_ff @(posedge HCLK) begin
        if (HRESET)       HRDATA <= 32'h0;
        else if (rd_fire) HRDATA <= rd_merged;
    end

    assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
    assign HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed bench for ahb_sram_slave (zero and three wait-state instances)
module tb_ahb_sram_slave;
    logic        clk;
    logic        rst;
    logic        sel0, sel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        ro0, ro3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rd0, rd3;
    logic [31:0] d;
    int          checks;
    int          failures;
    int          n;

    ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HWDATA(hwdata), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HWDATA(hwdata), .HREADY(ro3), .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic s3, input logic [31:0] a, input logic w, input logic [2:0] sz);
        sel0   = !s3;
        sel3   = s3;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic go_idle();
        sel0   = 1'b0;
        sel3   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic write0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] data);
        addr_ph(1'b0, a, 1'b1, sz);
        tick();
        hwdata = data;
        go_idle();
        tick();
    endtask

    task automatic read0(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] data);
        addr_ph(1'b0, a, 1'b0, sz);
        tick();
        go_idle();
        data = rd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go_idle();
        tick();
        tick();
        checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", ro0); end
        checks++; if (resp0 !== 2'b00) begin failures++; $display("FAIL reset_resp0 got=%b exp=00", resp0); end
        checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rd0); end
        checks++; if (ro3 !== 1'b1) begin failures++; $display("FAIL reset_ready3 got=%b exp=1", ro3); end
        checks++; if (resp3 !== 2'b00) begin failures++; $display("FAIL reset_resp3 got=%b exp=00", resp3); end
        checks++; if (rd3 !== 32'h0) begin failures++; $display("FAIL reset_rdata3 got=%h exp=0", rd3); end
        rst = 1'b0;
    endtask

    task automatic test_word_rw();
        addr_ph(1'b0, 32'h10, 1'b1, 3'd2);
        tick();
        checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL word_wr_ready got=%b exp=1", ro0); end
        hwdata = 32'hDEADBEEF;
        go_idle();
        tick();
        read0(32'h10, 3'd2, d);
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL word_read got=%h exp=deadbeef", d); end
        checks++; if (ro0 !== 1'b1 || resp0 !== 2'b00) begin failures++; $display("FAIL word_read_resp got=%b/%b exp=1/00", ro0, resp0); end
        tick();
    endtask

    task automatic test_lanes();
        write0(32'h10, 3'd2, 32'h11223344);
        write0(32'h13, 3'd0, 32'hAA000000);
        read0(32'h10, 3'd2, d);
        checks++; if (d !== 32'hAA223344) begin failures++; $display("FAIL byte_lane3 got=%h exp=aa223344", d); end
        tick();
        write0(32'h10, 3'd1, 32'h00005566);
        read0(32'h10, 3'd2, d);
        checks++; if (d !== 32'hAA225566) begin failures++; $display("FAIL half_low got=%h exp=aa225566", d); end
        tick();
        write0(32'h11, 3'd0, 32'h00007700);
        write0(32'h12, 3'd1, 32'h99880000);
        read0(32'h10, 3'd2, d);
        checks++; if (d !== 32'h99887766) begin failures++; $display("FAIL byte1_half_high got=%h exp=99887766", d); end
        tick();
    endtask

    task automatic test_forward();
        addr_ph(1'b0, 32'h20, 1'b1, 3'd2);
        tick();
        hwdata = 32'h12345678;
        addr_ph(1'b0, 32'h20, 1'b0, 3'd2);
        tick();
        go_idle();
        checks++; if (rd0 !== 32'h12345678) begin failures++; $display("FAIL fwd_word got=%h exp=12345678", rd0); end
        tick();
        addr_ph(1'b0, 32'h21, 1'b1, 3'd0);
        tick();
        hwdata = 32'h0000CC00;
        addr_ph(1'b0, 32'h20, 1'b0, 3'd2);
        tick();
        go_idle();
        checks++; if (rd0 !== 32'h1234CC78) begin failures++; $display("FAIL fwd_byte got=%h exp=1234cc78", rd0); end
        tick();
    endtask

    task automatic test_back_to_back();
        addr_ph(1'b0, 32'h10, 1'b0, 3'd2);
        tick();
        addr_ph(1'b0, 32'h20, 1'b0, 3'd2);
        checks++; if (rd0 !== 32'h99887766) begin failures++; $display("FAIL b2b_first got=%h exp=99887766", rd0); end
        checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ro0); end
        tick();
        go_idle();
        checks++; if (rd0 !== 32'h1234CC78) begin failures++; $display("FAIL b2b_second got=%h exp=1234cc78", rd0); end
        tick();
        tick();
        checks++; if (rd0 !== 32'h1234CC78) begin failures++; $display("FAIL hold_idle got=%h exp=1234cc78", rd0); end
        write0(32'h30, 3'd2, 32'h0BADF00D);
        checks++; if (rd0 !== 32'h1234CC78) begin failures++; $display("FAIL hold_write got=%h exp=1234cc78", rd0); end
    endtask

    task automatic test_error();
        write0(32'h0, 3'd2, 32'h01020304);
        addr_ph(1'b0, 32'h1000, 1'b1, 3'd2);
        tick();
        checks++; if (ro0 !== 1'b0 || resp0 !== 2'b01) begin failures++; $display("FAIL oob_err1 got=%b/%b exp=0/01", ro0, resp0); end
        hwdata = 32'hFFFFFFFF;
        addr_ph(1'b0, 32'h20, 1'b0, 3'd2);
        tick();
        go_idle();
        checks++; if (ro0 !== 1'b1 || resp0 !== 2'b01) begin failures++; $display("FAIL oob_err2 got=%b/%b exp=1/01", ro0, resp0); end
        checks++; if (rd0 !== 32'h1234CC78) begin failures++; $display("FAIL err_hold got=%h exp=1234cc78", rd0); end
        tick();
        checks++; if (ro0 !== 1'b1 || resp0 !== 2'b00) begin failures++; $display("FAIL err_after got=%b/%b exp=1/00", ro0, resp0); end
        read0(32'h0, 3'd2, d);
        checks++; if (d !== 32'h01020304) begin failures++; $display("FAIL oob_no_wrap got=%h exp=01020304", d); end
        tick();
        addr_ph(1'b0, 32'h10, 1'b1, 3'd3);
        tick();
        checks++; if (ro0 !== 1'b0 || resp0 !== 2'b01) begin failures++; $display("FAIL size_err1 got=%b/%b exp=0/01", ro0, resp0); end
        hwdata = 32'hFFFFFFFF;
        go_idle();
        tick();
        checks++; if (ro0 !== 1'b1 || resp0 !== 2'b01) begin failures++; $display("FAIL size_err2 got=%b/%b exp=1/01", ro0, resp0); end
        tick();
        read0(32'h10, 3'd2, d);
        checks++; if (d !== 32'h99887766) begin failures++; $display("FAIL size_err_nowrite got=%h exp=99887766", d); end
        tick();
        write0(32'hFFC, 3'd2, 32'hA5A5A5A5);
        read0(32'hFFC, 3'd2, d);
        checks++; if (d !== 32'hA5A5A5A5 || resp0 !== 2'b00) begin failures++; $display("FAIL last_word got=%h/%b exp=a5a5a5a5/00", d, resp0); end
        tick();
    endtask

    task automatic test_align();
`ifdef AHB_SRAM_ALIGN_CHECK_EN
        addr_ph(1'b0, 32'h02, 1'b1, 3'd2);
        tick();
        checks++; if (ro0 !== 1'b0 || resp0 !== 2'b01) begin failures++; $display("FAIL align_err1 got=%b/%b exp=0/01", ro0, resp0); end
        hwdata = 32'hFFFFFFFF;
        go_idle();
        tick();
        checks++; if (ro0 !== 1'b1 || resp0 !== 2'b01) begin failures++; $display("FAIL align_err2 got=%b/%b exp=1/01", ro0, resp0); end
        tick();
        read0(32'h0, 3'd2, d);
        checks++; if (d !== 32'h01020304) begin failures++; $display("FAIL align_nowrite got=%h exp=01020304", d); end
        tick();
`else
        read0(32'h12, 3'd2, d);
        checks++; if (d !== 32'h99887766 || resp0 !== 2'b00) begin failures++; $display("FAIL misalign_word got=%h/%b exp=99887766/00", d, resp0); end
        tick();
        read0(32'h13, 3'd1, d);
        checks++; if (d !== 32'h99887766 || resp0 !== 2'b00) begin failures++; $display("FAIL misalign_half got=%h/%b exp=99887766/00", d, resp0); end
        tick();
`endif
    endtask

    task automatic test_wait_states();
        addr_ph(1'b1, 32'h40, 1'b1, 3'd2);
        tick();
        hwdata = 32'hCAFEF00D;
        go_idle();
        for (n = 0; n < 20 && ro3 !== 1'b1; n++) begin
            checks++; if (resp3 !== 2'b00) begin failures++; $display("FAIL ws_wr_resp got=%b exp=00", resp3); end
            tick();
        end
        checks++; if (n != 3) begin failures++; $display("FAIL ws_wr_waits got=%0d exp=3", n); end
        tick();
        addr_ph(1'b1, 32'h40, 1'b0, 3'd2);
        tick();
        go_idle();
        checks++; if (rd3 !== 32'h0) begin failures++; $display("FAIL ws_rd_early got=%h exp=0", rd3); end
        for (n = 0; n < 20 && ro3 !== 1'b1; n++) begin
            checks++; if (resp3 !== 2'b00) begin failures++; $display("FAIL ws_rd_resp got=%b exp=00", resp3); end
            tick();
        end
        checks++; if (n != 3) begin failures++; $display("FAIL ws_rd_waits got=%0d exp=3", n); end
        checks++; if (rd3 !== 32'hCAFEF00D) begin failures++; $display("FAIL ws_rd_data got=%h exp=cafef00d", rd3); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        addr_ph(1'b1, 32'h40, 1'b1, 3'd2);
        tick();
        hwdata = 32'hFFFFFFFF;
        go_idle();
        checks++; if (ro3 !== 1'b0) begin failures++; $display("FAIL rst_wait_entry got=%b exp=0", ro3); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ro3 !== 1'b1 || resp3 !== 2'b00) begin failures++; $display("FAIL rst_wait_resp got=%b/%b exp=1/00", ro3, resp3); end
        checks++; if (rd3 !== 32'h0) begin failures++; $display("FAIL rst_wait_rdata got=%h exp=0", rd3); end
        tick();
        addr_ph(1'b1, 32'h40, 1'b0, 3'd2);
        tick();
        go_idle();
        for (n = 0; n < 20 && ro3 !== 1'b1; n++) tick();
        checks++; if (n != 3) begin failures++; $display("FAIL rst_rd_waits got=%0d exp=3", n); end
        checks++; if (rd3 !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_mem_kept got=%h exp=cafef00d", rd3); end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sel0     = 1'b0;
        sel3     = 1'b0;
        haddr    = 32'h0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hsize    = 3'd2;
        hburst   = 3'd0;
        hprot    = 4'd0;
        hwdata   = 32'h0;
        test_reset();
        test_word_rw();
        test_lanes();
        test_forward();
        test_back_to_back();
        test_error();
        test_align();
        test_wait_states();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
